// File: rtl/pre_process_sched_pkg.sv
// Shared types and constants for the channel pre-processing scheduler.
package pre_process_sched_pkg;

    localparam int NUSER   = 16;
    localparam int RES_W   = 24;
    localparam int MAX_OUT = 4;
    localparam int NGRAM   = 136;
    localparam int NJOBS   = 152;

    localparam logic [4:0] SEL_Y = 5'd16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Destination of an in-flight job: Gram entry (row,col) or y_out[row] when col==SEL_Y.
    typedef struct packed {
        logic [3:0] row;
        logic [4:0] col;
    } tag_t;

endpackage

// File: rtl/pre_process_sched_if.sv
// Engine issue/return channel and result-buffer write port of the scheduler.
interface pre_process_sched_if;
    import pre_process_sched_pkg::*;

    logic                    iss_valid;
    logic                    iss_ready;
    logic [3:0]              iss_sel_a;
    logic [4:0]              iss_sel_b;
    logic                    res_valid;
    logic signed [RES_W-1:0] res_data;
    logic                    wr_en;
    logic [3:0]              wr_row;
    logic [4:0]              wr_col;
    logic                    wr_mirror;
    logic signed [RES_W-1:0] wr_data;

    modport master (
        output iss_valid, iss_sel_a, iss_sel_b,
        output wr_en, wr_row, wr_col, wr_mirror, wr_data,
        input  iss_ready, res_valid, res_data
    );

    modport slave (
        input  iss_valid, iss_sel_a, iss_sel_b,
        input  wr_en, wr_row, wr_col, wr_mirror, wr_data,
        output iss_ready, res_valid, res_data
    );

endinterface

// File: rtl/pre_process_tag_fifo.sv
// Small synchronous FIFO holding the destination tags of jobs inside the engine.
module pre_process_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rptr];

    // Storage is not reset; only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pre_process_sched.sv
// Sequences Gram (A = H^H.H, upper triangle) and matched-filter (H^H.y) jobs over
// one shared pipelined dot-product engine and steers results to the A/y buffer.
//
//   state    | meaning
//   ---------+------------------------------------------------------
//   ST_IDLE  | waiting for start
//   ST_ISSUE | offering jobs to the engine, 136 Gram then 16 y jobs
//   ST_DRAIN | all jobs issued, waiting for the engine to empty
//   ST_DONE  | one-cycle done pulse
module pre_process_sched
    import pre_process_sched_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic done,
    output logic err_ovf,
    pre_process_sched_if.master bus
);

    state_t     state;
    state_t     state_nx;
    logic [3:0] row_idx;
    logic [4:0] col_idx;
    logic [7:0] job_cnt;
    logic [2:0] outstanding;
    logic       iss_valid_c;
    logic       handshake;
    logic       pop;
    logic       last_job;
    logic       fifo_empty;
    logic       fifo_full;
    tag_t       push_tag;
    tag_t       pop_tag;

    assign bus.iss_valid = iss_valid_c;
    assign bus.iss_sel_a = row_idx;
    assign bus.iss_sel_b = col_idx;
    assign handshake     = iss_valid_c & bus.iss_ready;
    assign pop           = bus.res_valid & ~fifo_empty;
    assign last_job      = (job_cnt == 8'(NJOBS - 1));
    assign push_tag      = '{row: row_idx, col: col_idx};

    pre_process_tag_fifo #(
        .DEPTH (MAX_OUT),
        .W     ($bits(tag_t))
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (handshake),
        .pop   (pop),
        .wdata (push_tag),
        .rdata (pop_tag),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // Next state and issue/status outputs; iss_valid depends only on registered
    // state so it cannot drop while a job waits for iss_ready.
    always_comb begin
        state_nx    = state;
        iss_valid_c = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) state_nx = ST_ISSUE;
            end
            ST_ISSUE: begin
                iss_valid_c = (outstanding < 3'(MAX_OUT)) && !fifo_full;
                if (iss_valid_c && bus.iss_ready && last_job) state_nx = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (outstanding == '0) state_nx = ST_DONE;
            end
            ST_DONE: begin
                done     = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Job index walker: row-major upper triangle, then y column for every row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_idx <= '0;
            col_idx <= '0;
            job_cnt <= '0;
        end else if (state == ST_IDLE && start) begin
            row_idx <= '0;
            col_idx <= '0;
            job_cnt <= '0;
        end else if (handshake) begin
            job_cnt <= job_cnt + 1'b1;
            if (col_idx == SEL_Y) begin
                row_idx <= row_idx + 1'b1;
            end else if (col_idx == 5'(NUSER - 1)) begin
                if (job_cnt == 8'(NGRAM - 1)) begin
                    row_idx <= '0;
                    col_idx <= SEL_Y;
                end else begin
                    row_idx <= row_idx + 1'b1;
                    col_idx <= {1'b0, row_idx} + 5'd1;
                end
            end else begin
                col_idx <= col_idx + 1'b1;
            end
        end
    end

    // Jobs inside the engine; a simultaneous issue and return cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
        end else begin
            case ({handshake, pop})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Registered writeback of each returned result; a return with no tag is flagged, not written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.wr_en     <= 1'b0;
            bus.wr_mirror <= 1'b0;
            bus.wr_row    <= '0;
            bus.wr_col    <= '0;
            bus.wr_data   <= '0;
            err_ovf       <= 1'b0;
        end else begin
            bus.wr_en     <= pop;
            bus.wr_mirror <= pop && (pop_tag.col != SEL_Y) && (pop_tag.col[3:0] != pop_tag.row);
            if (pop) begin
                bus.wr_row  <= pop_tag.row;
                bus.wr_col  <= pop_tag.col;
                bus.wr_data <= bus.res_data;
            end
            if (bus.res_valid && fifo_empty) err_ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pre_process_sched.sv
// Directed bench for pre_process_sched with a latency-configurable engine model.
module tb_pre_process_sched;
    import pre_process_sched_pkg::*;

    typedef struct {
        int               due;
        logic [RES_W-1:0] data;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic busy, done, err_ovf;

    pre_process_sched_if bus();

    pre_process_sched dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .err_ovf (err_ovf),
        .bus     (bus)
    );

    initial forever #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    int exp_a [NJOBS];
    int exp_b [NJOBS];
    int hmat  [8][NUSER];
    int yv    [8];
    int gold  [NUSER][NUSER+1];
    rsp_t eq [$];

    int cyc = 0, c0 = 0, lat = 2;
    bit rdy_rand = 0, spur = 0;
    bit issuing = 0, drain = 0, done_pend = 0, prev_ret = 0, err_m = 0;
    int k, wk, out_m, max_out, hs_cnt, wr_cnt, mir_cnt, diag_cnt, y_cnt, done_cnt;
    int first_hs_cyc, first_wr_cyc, last_wr_cyc, done_cyc, first_gap, gap_run;
    int first_wr_row, first_wr_col, last_wr_row, last_wr_col;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        hs_cnt = 0; wr_cnt = 0; mir_cnt = 0; diag_cnt = 0; y_cnt = 0; done_cnt = 0;
        max_out = 0; first_gap = -1; gap_run = 0;
        first_hs_cyc = -1; first_wr_cyc = -1; last_wr_cyc = -1; done_cyc = -1;
        first_wr_row = -1; first_wr_col = -1; last_wr_row = -1; last_wr_col = -1;
    endtask

    // One clock cycle: check outputs mid-cycle against the model, drive the engine, update the model.
    task automatic tick(input logic st);
        logic ret, hs, exp_done, was_idle, spur_now;
        int   sa, sb;
        rsp_t r;
        @(negedge clk);
        cyc++;
        exp_done = done_pend;
        was_idle = !issuing && !drain && !exp_done;

        if (prev_ret) begin
            chk("wr_en", 32'(bus.wr_en), 32'd1);
            if (wk < NJOBS) begin
                chk("wr_row", 32'(bus.wr_row), exp_a[wk]);
                chk("wr_col", 32'(bus.wr_col), exp_b[wk]);
                chk("wr_mirror", 32'(bus.wr_mirror), 32'((exp_b[wk] != NUSER) && (exp_b[wk] != exp_a[wk])));
                chk("wr_data", 32'(bus.wr_data), gold[exp_a[wk]][exp_b[wk]]);
                wk++;
            end
        end else begin
            chk("wr_en_idle", 32'(bus.wr_en), 32'd0);
        end
        if (bus.wr_en) begin
            if (wr_cnt == 0) begin
                first_wr_cyc = cyc; first_wr_row = int'(bus.wr_row); first_wr_col = int'(bus.wr_col);
            end
            last_wr_cyc = cyc; last_wr_row = int'(bus.wr_row); last_wr_col = int'(bus.wr_col);
            wr_cnt++;
            if (bus.wr_mirror) mir_cnt++;
            if (bus.wr_col == 5'd16) y_cnt++;
            else if (bus.wr_col == {1'b0, bus.wr_row}) diag_cnt++;
        end

        chk("err_ovf", 32'(err_ovf), 32'(err_m));
        chk("done", 32'(done), 32'(exp_done));
        chk("busy", 32'(busy), 32'(issuing || drain || exp_done));
        if (done) begin
            if (done_cnt == 0) done_cyc = cyc;
            done_cnt++;
        end
        done_pend = drain && (out_m == 0);
        if (done_pend) drain = 0;

        ret = 0;
        spur_now = spur;
        if (spur) begin
            bus.res_valid = 1'b1; bus.res_data = 24'sh05A5A5; spur = 0;
        end else if (eq.size() > 0 && eq[0].due <= cyc) begin
            bus.res_valid = 1'b1; bus.res_data = eq[0].data; void'(eq.pop_front()); ret = 1;
        end else begin
            bus.res_valid = 1'b0; bus.res_data = '0;
        end
        bus.iss_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;

        chk("iss_valid", 32'(bus.iss_valid), 32'(issuing && (out_m < MAX_OUT)));
        if (issuing) begin
            if (!bus.iss_valid) gap_run++;
            else begin
                if (gap_run > 0 && first_gap < 0) first_gap = gap_run;
                gap_run = 0;
            end
        end
        if (bus.iss_valid && k < NJOBS) begin
            chk("iss_sel_a", 32'(bus.iss_sel_a), exp_a[k]);
            chk("iss_sel_b", 32'(bus.iss_sel_b), exp_b[k]);
        end
        hs = bus.iss_valid && bus.iss_ready;
        if (hs) begin
            sa = int'(bus.iss_sel_a);
            sb = int'(bus.iss_sel_b);
            r.due  = cyc + lat;
            r.data = (sb <= NUSER) ? RES_W'(gold[sa][sb]) : '0;
            eq.push_back(r);
            if (hs_cnt == 0) first_hs_cyc = cyc;
            hs_cnt++;
            k++;
            if (k == NJOBS) begin issuing = 0; drain = 1; end
        end

        if (spur_now && out_m == 0) err_m = 1;
        out_m = out_m + int'(hs) - int'(ret);
        if (out_m > max_out) max_out = out_m;
        prev_ret = ret;

        start = st;
        if (st && was_idle && !rst) begin
            issuing = 1; k = 0; wk = 0; c0 = cyc;
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_iss_valid", 32'(bus.iss_valid), 32'd0);
        chk("rst_sel_a", 32'(bus.iss_sel_a), 32'd0);
        chk("rst_sel_b", 32'(bus.iss_sel_b), 32'd0);
        chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
        chk("rst_wr_mirror", 32'(bus.wr_mirror), 32'd0);
        chk("rst_wr_row", 32'(bus.wr_row), 32'd0);
        chk("rst_wr_col", 32'(bus.wr_col), 32'd0);
        chk("rst_wr_data", 32'(bus.wr_data), 32'd0);
        chk("rst_err_ovf", 32'(err_ovf), 32'd0);
        eq.delete();
        bus.res_valid = 1'b0; bus.res_data = '0; bus.iss_ready = 1'b0; start = 1'b0;
        issuing = 0; drain = 0; done_pend = 0; prev_ret = 0; err_m = 0;
        k = 0; wk = 0; out_m = 0;
        tick(1'b0);
        tick(1'b0);
        rst = 1'b0;
    endtask

    task automatic run(input int lat_i, input bit rnd, input bit ds, input bit nominal, input string name);
        int n;
        bit ds_sent;
        lat = lat_i; rdy_rand = rnd;
        clear_stats();
        tick(1'b1);
        n = 0; ds_sent = 0;
        while (done_cnt == 0 && n < 4000) begin
            if (ds && drain && !ds_sent) begin ds_sent = 1; tick(1'b1); end
            else tick(1'b0);
            n++;
        end
        chk({name, "_finished"}, 32'(done_cnt > 0), 32'd1);
        for (int i = 0; i < 12; i++) tick(1'b0);
        chk({name, "_done_pulses"}, done_cnt, 1);
        chk({name, "_issues"}, hs_cnt, NJOBS);
        chk({name, "_writes"}, wr_cnt, NJOBS);
        chk({name, "_mirrored"}, mir_cnt, 120);
        chk({name, "_diag"}, diag_cnt, 16);
        chk({name, "_y"}, y_cnt, 16);
        chk({name, "_first_wr_row"}, first_wr_row, 0);
        chk({name, "_first_wr_col"}, first_wr_col, 0);
        chk({name, "_last_wr_row"}, last_wr_row, 15);
        chk({name, "_last_wr_col"}, last_wr_col, 16);
        chk({name, "_busy_after"}, 32'(busy), 32'd0);
        if (nominal) begin
            chk({name, "_first_hs_cyc"}, first_hs_cyc - c0, 1);
            chk({name, "_first_wr_cyc"}, first_wr_cyc - c0, 4);
            chk({name, "_last_wr_cyc"}, last_wr_cyc - c0, 155);
            chk({name, "_done_cyc"}, done_cyc - c0, 156);
        end
    endtask

    initial begin
        int n;
        bus.iss_ready = 1'b0; bus.res_valid = 1'b0; bus.res_data = '0;
        for (int r = 0; r < 8; r++) begin
            yv[r] = int'($urandom_range(0, 255)) - 128;
            for (int c = 0; c < NUSER; c++) hmat[r][c] = int'($urandom_range(0, 255)) - 128;
        end
        for (int i = 0; i < NUSER; i++) begin
            for (int j = 0; j <= NUSER; j++) begin
                gold[i][j] = 0;
                for (int r = 0; r < 8; r++)
                    gold[i][j] += hmat[r][i] * ((j == NUSER) ? yv[r] : hmat[r][j]);
            end
        end
        n = 0;
        for (int i = 0; i < NUSER; i++)
            for (int j = i; j < NUSER; j++) begin exp_a[n] = i; exp_b[n] = j; n++; end
        for (int i = 0; i < NUSER; i++) begin exp_a[n] = i; exp_b[n] = NUSER; n++; end
        clear_stats();

        #2;
        apply_reset();

        run(2, 1'b0, 1'b0, 1'b1, "nominal");
        run(2, 1'b1, 1'b0, 1'b0, "backpressure");

        run(10, 1'b0, 1'b0, 1'b0, "inflight");
        chk("inflight_max_out", max_out, 4);
        chk("inflight_gap", first_gap, 7);

        spur = 1;
        tick(1'b0);
        tick(1'b0);
        tick(1'b0);
        chk("spur_err_set", 32'(err_ovf), 32'd1);
        run(2, 1'b0, 1'b0, 1'b1, "after_spur");
        chk("spur_err_sticky", 32'(err_ovf), 32'd1);

        lat = 2; rdy_rand = 0;
        clear_stats();
        tick(1'b1);
        n = 0;
        while (k < 60 && n < 500) begin tick(1'b0); n++; end
        chk("midrun_reached_60", 32'(k >= 60), 32'd1);
        apply_reset();
        run(2, 1'b0, 1'b0, 1'b1, "post_reset");

        run(2, 1'b0, 1'b1, 1'b1, "start_in_drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
